// File: rtl/bcd_pkg.sv
// Shared constants and FSM state encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam int BASE    = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CONV = ST_CONV,
    HOLD = ST_HOLD
  } state_t;

endpackage

// File: rtl/bcd_seq_converter_div10_step.sv
// Combinational divide-by-10: restoring long division, one quotient bit per input bit.
module div10_step
  import bcd_pkg::*;
#(
  parameter int K = 16
) (
  input  logic [K-1:0]       n,
  output logic [K-1:0]       q,
  output logic [DIGIT_W-1:0] r
);

  localparam logic [DIGIT_W:0] BASE_W = (DIGIT_W+1)'(BASE);

  // The running remainder stays below BASE, so one extra bit covers the shift-in.
  logic [DIGIT_W:0] rem;

  always_comb begin
    q   = '0;
    rem = '0;
    for (int i = K-1; i >= 0; i--) begin
      rem = {rem[DIGIT_W-1:0], n[i]};
      if (rem >= BASE_W) begin
        q[i] = 1'b1;
        rem  = rem - BASE_W;
      end
    end
    r = rem[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle binary-to-BCD converter: one shared divide-by-10 per clock, valid/ready on both sides.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] number,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] text,
  output logic         ovf,
  output logic         busy
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

  state_t             state, state_nxt;
  logic [N-1:0]       work, acc, acc_dig, q;
  logic [DIGIT_W-1:0] r;
  logic [IDX_W-1:0]   idx;
  logic               accept, conv, last;

  div10_step #(.K(N)) u_div10 (
    .n (work),
    .q (q),
    .r (r)
  );

  assign accept  = (state == IDLE) && in_valid;
  assign conv    = (state == CONV);
  // Stop on a zero quotient so digits above the last significant one stay 0.
  assign last    = (q == '0) || (idx == IDX_LAST);
  assign acc_dig = acc | ({{(N-DIGIT_W){1'b0}}, r} << (DIGIT_W * idx));

  assign in_ready  = (state == IDLE);
  assign busy      = conv;
  assign out_valid = (state == HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CONV;
      CONV:    if (last)      state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      text  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        idx <= '0;
      else if (conv && !last)
        idx <= idx + 1'b1;
      if (conv && last) begin
        text <= acc_dig;
        ovf  <= (q != '0);
      end
    end
  end

  // Datapath registers are always loaded on accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      work <= number;
      acc  <= '0;
    end else if (conv) begin
      work <= q;
      acc  <= acc_dig;
    end
  end

endmodule
